// File: rtl/i2s_slave_rx.sv
// I2S slave receiver: oversamples externally clocked LRCK/SCLK/SDATA on mclk_in and
// presents MSB-justified stereo frames on a valid/ready interface.
module i2s_slave_rx #(
    parameter int unsigned PDATA_WIDTH = 32
) (
    input  logic                   mclk_in,
    input  logic                   arstn_in,
    input  logic                   lrck_in,
    input  logic                   sclk_in,
    input  logic                   sdata_in,
    output logic [PDATA_WIDTH-1:0] pldata_out,
    output logic [PDATA_WIDTH-1:0] prdata_out,
    output logic                   pvalid_out,
    input  logic                   pready_in,
    output logic                   overrun_out,
    input  logic                   overrun_clr_in
);

    localparam int unsigned CW = $clog2(PDATA_WIDTH + 1);
    localparam int unsigned IW = $clog2(PDATA_WIDTH);

    typedef enum logic {UNLOCKED, LOCKED} lock_e;

    logic [1:0]             lr_sync_q;
    logic [2:0]             sck_sync_q;
    logic [1:0]             sd_sync_q;
    logic                   lr_prev_q, lr_prev_d;
    lock_e                  state_q, state_d;
    logic [PDATA_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [PDATA_WIDTH-1:0] lhold_q, lhold_d;
    logic                   lheld_q, lheld_d;
    logic [PDATA_WIDTH-1:0] pldata_q, pldata_d;
    logic [PDATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                   pvalid_q, pvalid_d;
    logic                   overrun_q, overrun_d;

    logic                   rise_c, lr_c, d_c, boundary_c, room_c;
    logic                   word_done_c, frame_c;
    logic [IW-1:0]          idx_c;
    logic [PDATA_WIDTH-1:0] word_c;

    // Synchronizer taps: ff1 = [0], ff2 = [1]; sck [2] delays ff2 for rise detection
    assign rise_c     = sck_sync_q[1] & ~sck_sync_q[2];
    assign lr_c       = lr_sync_q[1];
    assign d_c        = sd_sync_q[1];
    assign boundary_c = rise_c && (lr_c != lr_prev_q);
    assign room_c     = cnt_q < CW'(PDATA_WIDTH);
    assign idx_c      = IW'(PDATA_WIDTH - 1) - cnt_q[IW-1:0];

    // Shift register with the current bit merged in; bits beyond the word width drop
    always_comb begin
        word_c = shift_q;
        if (room_c) begin
            word_c[idx_c] = d_c;
        end
    end

    always_comb begin
        lr_prev_d   = lr_prev_q;
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        lhold_d     = lhold_q;
        lheld_d     = lheld_q;
        pldata_d    = pldata_q;
        prdata_d    = prdata_q;
        pvalid_d    = pvalid_q;
        overrun_d   = overrun_q;
        word_done_c = 1'b0;
        frame_c     = 1'b0;

        if (rise_c) begin
            lr_prev_d = lr_c;
            case (state_q)
                UNLOCKED: begin
                    if (boundary_c) begin
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (boundary_c) begin
                        word_done_c = 1'b1;
                        shift_d     = '0;
                        cnt_d       = '0;
                    end else if (room_c) begin
                        shift_d = word_c;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end

        // A right word only forms a frame when a left word is waiting for it
        if (word_done_c) begin
            if (!lr_prev_q) begin
                lhold_d = word_c;
                lheld_d = 1'b1;
            end else if (lheld_q) begin
                frame_c = 1'b1;
                lheld_d = 1'b0;
            end
        end

        if (pvalid_q && pready_in) begin
            pvalid_d = 1'b0;
        end
        if (overrun_clr_in) begin
            overrun_d = 1'b0;
        end
        if (frame_c) begin
            if (!pvalid_q || pready_in) begin
                pldata_d = lhold_q;
                prdata_d = word_c;
                pvalid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge mclk_in or negedge arstn_in) begin
        if (!arstn_in) begin
            lr_sync_q  <= '0;
            sck_sync_q <= '0;
            sd_sync_q  <= '0;
            lr_prev_q  <= 1'b0;
            state_q    <= UNLOCKED;
            shift_q    <= '0;
            cnt_q      <= '0;
            lhold_q    <= '0;
            lheld_q    <= 1'b0;
            pldata_q   <= '0;
            prdata_q   <= '0;
            pvalid_q   <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            lr_sync_q  <= {lr_sync_q[0], lrck_in};
            sck_sync_q <= {sck_sync_q[1:0], sclk_in};
            sd_sync_q  <= {sd_sync_q[0], sdata_in};
            lr_prev_q  <= lr_prev_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            lhold_q    <= lhold_d;
            lheld_q    <= lheld_d;
            pldata_q   <= pldata_d;
            prdata_q   <= prdata_d;
            pvalid_q   <= pvalid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign pldata_out  = pldata_q;
    assign prdata_out  = prdata_q;
    assign pvalid_out  = pvalid_q;
    assign overrun_out = overrun_q;

endmodule

// File: tb/tb_i2s_slave_rx.sv
// Bench for i2s_slave_rx: drives an I2S master stream and checks received frames
// against word/frame expectations derived from the sent samples.
module tb_i2s_slave_rx;

    logic        mclk = 1'b0;
    logic        arstn, lrck, sclk, sdata, pready, ovr_clr;
    logic [31:0] pl32, pr32;
    logic [15:0] pl16, pr16;
    logic        pv32, pv16, ovr32, ovr16;

    always #5 mclk = ~mclk;

    i2s_slave_rx #(.PDATA_WIDTH(32)) dut32 (
        .mclk_in(mclk), .arstn_in(arstn), .lrck_in(lrck), .sclk_in(sclk), .sdata_in(sdata),
        .pldata_out(pl32), .prdata_out(pr32), .pvalid_out(pv32), .pready_in(pready),
        .overrun_out(ovr32), .overrun_clr_in(ovr_clr));

    i2s_slave_rx #(.PDATA_WIDTH(16)) dut16 (
        .mclk_in(mclk), .arstn_in(arstn), .lrck_in(lrck), .sclk_in(sclk), .sdata_in(sdata),
        .pldata_out(pl16), .prdata_out(pr16), .pvalid_out(pv16), .pready_in(pready),
        .overrun_out(ovr16), .overrun_clr_in(ovr_clr));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mark_n, first_valid_cyc, pv_rises;
    logic prev_pv = 1'b0;
    logic rand_ready = 1'b0;
    logic [63:0] fl [8];
    logic [63:0] fr [8];
    logic [63:0] got32 [$];
    logic [31:0] got16 [$];
    logic        pre_pv, pre_ovr, rst_pv, rst_ovr;
    logic [31:0] pre_pl, rst_data;

    always @(posedge mclk) cyc++;

    // Record every accepted frame and the first pvalid assertion after reset
    always @(negedge mclk) begin
        if (arstn) begin
            if (pv32 && pready) got32.push_back({pl32, pr32});
            if (pv16 && pready) got16.push_back({pl16, pr16});
            if (pv32 && !prev_pv) begin
                pv_rises++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
        end
        prev_pv = pv32;
    end

    always @(posedge mclk) begin
        if (rand_ready) begin
            #1;
            pready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    // Reference: an n-bit slot word seen through a pw-bit MSB-justified receiver
    function automatic logic [31:0] exp_word(input logic [63:0] w, input int n, input int pw);
        logic [63:0] m;
        m = w & ((64'd1 << n) - 64'd1);
        if (n >= pw) m = m >> (n - pw);
        else         m = m << (pw - n);
        m = m & ((64'd1 << pw) - 64'd1);
        return m[31:0];
    endfunction

    function automatic logic [63:0] exp32(input int f, input int n);
        return {exp_word(fl[f], n, 32), exp_word(fr[f], n, 32)};
    endfunction

    function automatic logic [31:0] exp16(input int f, input int n);
        logic [31:0] l, r;
        l = exp_word(fl[f], n, 16);
        r = exp_word(fr[f], n, 16);
        return {l[15:0], r[15:0]};
    endfunction

    // Serial bit j of the stream: frames back to back, left then right, MSB first
    function automatic logic bit_at(input int j, input int n, input int nfr);
        logic [63:0] w, s;
        if (j < 0 || j >= nfr * 2 * n) return 1'b0;
        w = (((j / n) % 2) == 1) ? fr[j / (2 * n)] : fl[j / (2 * n)];
        s = w >> (n - 1 - (j % n));
        return s[0];
    endfunction

    task automatic rand_frames(input int n);
        for (int i = 0; i < 8; i++) begin
            fl[i] = {$urandom(), $urandom()} & ((64'd1 << n) - 64'd1);
            fr[i] = {$urandom(), $urandom()} & ((64'd1 << n) - 64'd1);
        end
    endtask

    // SCLK = MCLK/8; LRCK/SDATA change on the falling edge, data one SCLK behind LRCK
    task automatic send(input int n, input int nfr, input int rst_at, input int mark_at);
        int total;
        total = nfr * 2 * n + 3;
        for (int k = 0; k < total; k++) begin
            @(posedge mclk); #2;
            sclk  = 1'b0;
            lrck  = (k < nfr * 2 * n) ? 1'((k / n) % 2) : 1'b0;
            sdata = bit_at(k - 1, n, nfr);
            if (k == rst_at) begin
                pre_pv = pv32; pre_ovr = ovr32; pre_pl = pl32;
                arstn = 1'b0;
                #1;
                rst_pv = pv32; rst_ovr = ovr32; rst_data = pl32 | pr32;
                pready = 1'b1;
                repeat (2) @(posedge mclk);
                #2 arstn = 1'b1;
            end
            repeat (4) @(posedge mclk); #2;
            sclk = 1'b1;
            if (k == mark_at) mark_n = cyc + 1;
            repeat (3) @(posedge mclk);
        end
        repeat (12) @(posedge mclk);
    endtask

    task automatic do_reset();
        arstn = 1'b0; sclk = 1'b0; lrck = 1'b0; sdata = 1'b0;
        pready = 1'b1; ovr_clr = 1'b0; rand_ready = 1'b0;
        repeat (3) @(posedge mclk);
        #2 arstn = 1'b1;
        got32.delete(); got16.delete();
        pv_rises = 0; first_valid_cyc = -1; mark_n = -1;
        @(posedge mclk);
    endtask

    task automatic test_reset();
        arstn = 1'b0; sclk = 1'b0; lrck = 1'b1; sdata = 1'b1; pready = 1'b1; ovr_clr = 1'b0;
        #1;
        checks++; if (pv32 !== 1'b0) begin errors++; $display("FAIL reset_pvalid: got %b exp 0", pv32); end
        checks++; if ({pl32, pr32} !== 64'd0) begin errors++; $display("FAIL reset_data: got %h exp 0", {pl32, pr32}); end
        checks++; if (ovr32 !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b exp 0", ovr32); end
        checks++; if (pv16 !== 1'b0) begin errors++; $display("FAIL reset_pvalid16: got %b exp 0", pv16); end
    endtask

    task automatic test_lock();
        do_reset();
        fl[0] = 64'hA5A5_0001; fr[0] = 64'h8000_00FF;
        fl[1] = 64'hA5A5_0001; fr[1] = 64'h8000_00FF;
        send(32, 2, -1, -1);
        checks++; if (got32.size() != 1) begin errors++; $display("FAIL lock_count: got %0d exp 1", got32.size()); end
        checks++; if (pv_rises != 1) begin errors++; $display("FAIL lock_pvalid_pulses: got %0d exp 1", pv_rises); end
        for (int i = 0; i < got32.size() && i < 1; i++) begin
            checks++;
            if (got32[i] !== 64'hA5A5_0001_8000_00FF) begin
                errors++; $display("FAIL lock_frame: got %h exp %h", got32[i], 64'hA5A5_0001_8000_00FF);
            end
        end
    endtask

    task automatic test_latency();
        do_reset();
        rand_frames(32);
        send(32, 2, -1, 128);
        checks++;
        if (first_valid_cyc != mark_n + 2) begin
            errors++; $display("FAIL latency: pvalid at edge %0d exp %0d", first_valid_cyc, mark_n + 2);
        end
        checks++;
        if (got32.size() != 1 || got32[0] !== exp32(1, 32)) begin
            errors++; $display("FAIL latency_frame: got %0d frames exp 1 of %h", got32.size(), exp32(1, 32));
        end
    endtask

    task automatic test_short_slots();
        do_reset();
        rand_frames(16);
        fl[1] = 64'h1234; fr[1] = 64'hFFFF;
        send(16, 3, -1, -1);
        checks++; if (got32.size() != 2) begin errors++; $display("FAIL short_count: got %0d exp 2", got32.size()); end
        for (int i = 0; i < got32.size() && i < 2; i++) begin
            checks++;
            if (got32[i] !== exp32(i + 1, 16)) begin
                errors++; $display("FAIL short_frame%0d: got %h exp %h", i, got32[i], exp32(i + 1, 16));
            end
        end
        checks++;
        if (got32.size() > 0 && got32[0] !== 64'h1234_0000_FFFF_0000) begin
            errors++; $display("FAIL short_literal: got %h exp 1234_0000_ffff_0000", got32[0]);
        end
    endtask

    task automatic test_long_slots();
        do_reset();
        rand_frames(32);
        fl[1] = 64'hBEEF_CAFE;
        send(32, 3, -1, -1);
        checks++; if (got16.size() != 2) begin errors++; $display("FAIL long_count: got %0d exp 2", got16.size()); end
        for (int i = 0; i < got16.size() && i < 2; i++) begin
            checks++;
            if (got16[i] !== exp16(i + 1, 32)) begin
                errors++; $display("FAIL long_frame%0d: got %h exp %h", i, got16[i], exp16(i + 1, 32));
            end
        end
        checks++;
        if (got16.size() > 0 && got16[0][31:16] !== 16'hBEEF) begin
            errors++; $display("FAIL long_literal: got %h exp beef", got16[0][31:16]);
        end
    endtask

    task automatic test_random();
        int slots [5] = '{8, 16, 24, 32, 40};
        int n, nfr;
        for (int it = 0; it < 5; it++) begin
            n   = slots[$urandom_range(0, 4)];
            nfr = $urandom_range(2, 5);
            do_reset();
            rand_frames(n);
            send(n, nfr, -1, -1);
            checks++;
            if (got32.size() != nfr - 1 || got16.size() != nfr - 1) begin
                errors++; $display("FAIL rand_count n=%0d: got %0d/%0d exp %0d", n, got32.size(), got16.size(), nfr - 1);
            end
            for (int i = 0; i < got32.size() && i < nfr - 1; i++) begin
                checks++;
                if (got32[i] !== exp32(i + 1, n)) begin
                    errors++; $display("FAIL rand32 n=%0d f%0d: got %h exp %h", n, i, got32[i], exp32(i + 1, n));
                end
            end
            for (int i = 0; i < got16.size() && i < nfr - 1; i++) begin
                checks++;
                if (got16[i] !== exp16(i + 1, n)) begin
                    errors++; $display("FAIL rand16 n=%0d f%0d: got %h exp %h", n, i, got16[i], exp16(i + 1, n));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        rand_frames(16);
        rand_ready = 1'b1;
        send(16, 6, -1, -1);
        rand_ready = 1'b0;
        #2 pready = 1'b1;
        repeat (4) @(posedge mclk);
        checks++; if (got32.size() != 5) begin errors++; $display("FAIL b2b_count: got %0d exp 5", got32.size()); end
        for (int i = 0; i < got32.size() && i < 5; i++) begin
            checks++;
            if (got32[i] !== exp32(i + 1, 16)) begin
                errors++; $display("FAIL b2b_frame%0d: got %h exp %h", i, got32[i], exp32(i + 1, 16));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        rand_frames(16);
        pready = 1'b0;
        send(16, 3, -1, -1);
        #1;
        checks++; if (pv32 !== 1'b1) begin errors++; $display("FAIL bp_pvalid: got %b exp 1", pv32); end
        checks++;
        if ({pl32, pr32} !== exp32(1, 16)) begin
            errors++; $display("FAIL bp_held: got %h exp %h", {pl32, pr32}, exp32(1, 16));
        end
        checks++; if (ovr32 !== 1'b1) begin errors++; $display("FAIL bp_overrun: got %b exp 1", ovr32); end
        @(posedge mclk); #1 ovr_clr = 1'b1;
        @(posedge mclk); #1 ovr_clr = 1'b0;
        checks++; if (ovr32 !== 1'b0) begin errors++; $display("FAIL bp_clear: got %b exp 0", ovr32); end
        checks++; if (pv32 !== 1'b1) begin errors++; $display("FAIL bp_still_valid: got %b exp 1", pv32); end
        pready = 1'b1;
        @(posedge mclk); #1;
        checks++; if (pv32 !== 1'b0) begin errors++; $display("FAIL bp_release: got %b exp 0", pv32); end
        checks++;
        if (got32.size() != 1 || got32[0] !== exp32(1, 16)) begin
            errors++; $display("FAIL bp_accepted: got %0d frames exp 1 of %h", got32.size(), exp32(1, 16));
        end
    endtask

    task automatic test_midreset();
        do_reset();
        rand_frames(32);
        fl[1] = fl[1] | 64'h8000_0000;
        pready = 1'b0;
        send(32, 6, 3 * 64 + 10, -1);
        checks++;
        if (pre_pv !== 1'b1 || pre_ovr !== 1'b1 || pre_pl !== exp_word(fl[1], 32, 32)) begin
            errors++; $display("FAIL mr_before: got v=%b o=%b l=%h exp v=1 o=1 l=%h", pre_pv, pre_ovr, pre_pl, exp_word(fl[1], 32, 32));
        end
        checks++;
        if (rst_pv !== 1'b0 || rst_ovr !== 1'b0 || rst_data !== 32'd0) begin
            errors++; $display("FAIL mr_async_clear: got v=%b o=%b d=%h exp 0 0 0", rst_pv, rst_ovr, rst_data);
        end
        checks++; if (got32.size() != 2) begin errors++; $display("FAIL mr_count: got %0d exp 2", got32.size()); end
        for (int i = 0; i < got32.size() && i < 2; i++) begin
            checks++;
            if (got32[i] !== exp32(i + 4, 32)) begin
                errors++; $display("FAIL mr_frame%0d: got %h exp %h", i, got32[i], exp32(i + 4, 32));
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_latency();
        test_short_slots();
        test_long_slots();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
